ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-port arbiter/sequencer in front of basic_ram: shares the single RAM between the ARMv4 core's instruction-fetch port and data port.
- Converts per-port req/ack handshakes into the RAM's cs/we/oe/mem_done protocol.
- Round-robin arbitration; one RAM access in flight at a time.
- Sits between the core's fetch/load-store units and basic_ram.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- TIMEOUT_CYC, 64, maximum ACCESS cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request (read only), held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data, registered.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  data write (1) / read (0).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_rdata  out  DATA_W  data read data, registered.
- d_ack  out  1  one-cycle data completion pulse.
- err  out  1  one-cycle abort pulse, coincident with the ack of the aborted access.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- ram_done  in  1  RAM access complete.

Behaviour:
- Reset state:
  - All outputs are 0; state is IDLE; last_grant = DATA, so fetch wins the first tie.
  - Reset is asynchronous: it drops ram_cs immediately, mid-access included.
  - A request held across reset is re-arbitrated from IDLE after rst_n rises; no ack is issued for the interrupted access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Only if_req: grant IF.
  - Only d_req: grant D.
  - Both: grant the port not in last_grant.
  - On grant, latch the port id, addr, we (IF: we=0) and wdata into registers, update last_grant, and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - ram_cs=1, ram_we=latched we, ram_oe=~latched we; ram_addr/ram_wdata come from the latched registers.
  - Outputs are stable for the whole state, whatever happens on the requester inputs.
  - Stay while ram_done=0.
  - On ram_done=1: for a read, capture ram_rdata into the granted port's rdata register; go to DONE.
- DONE:
  - ram_cs/ram_we/ram_oe = 0; the granted port's ack = 1 for exactly this cycle.
  - Unconditionally return to IDLE.
- Latency:
  - Request sampled at edge E0, ram_done sampled high at edge E1 → ack high during the cycle after E1.
  - Minimum request-to-ack is 2 edges; each access occupies at least 3 cycles.
- Handshake:
  - Requester deasserts req on the edge where it samples ack=1.
  - The arbiter is in IDLE on that same edge, so no duplicate grant occurs.
  - Requester inputs may change freely while not granted.
- Read data:
  - if_rdata/d_rdata hold their value until the next completed read on that port.
  - Writes never modify d_rdata.
- Write data: d_wdata is ignored when d_we=0.
- Fairness: back-to-back contention strictly alternates IF, D, IF, D...; neither port waits more than one foreign access.
- ram_done outside ACCESS is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If the counter reaches TIMEOUT_CYC-1 with ram_done still 0, go to DONE.
  - In DONE: ack pulses with err=1; a read loads rdata with 0.
  - A ram_done arriving in the same cycle as the timeout wins: normal completion, err=0.
- Not defined: ACCESS waits indefinitely for ram_done, and err is tied to 0.

Test Plan:
- Reset then if_req, if_addr=0x10, RAM returns 0xE3A00001 with ram_done one cycle after cs → ram_oe=1, ram_addr=0x10; if_ack pulses once 2 edges after req; if_rdata=0xE3A00001.
- d_req, d_we=1, d_addr=0x20, d_wdata=0xCAFEF00D → ram_we=1, ram_oe=0, ram_wdata=0xCAFEF00D; d_ack pulses once; d_rdata is unchanged.
- if_req and d_req asserted together from reset and held for 4 accesses → grant order IF, D, IF, D; each ack lasts exactly 1 cycle; ram_cs is low in every DONE cycle.
- rst_n pulsed low during ACCESS of a D read → ram_cs goes to 0 without waiting for a clock edge; no d_ack; after release, the held d_req completes normally.
- MEM_TIMEOUT_EN with TIMEOUT_CYC=8 and ram_done never asserted on an IF read → if_ack and err pulse together 8 cycles after ACCESS entry; if_rdata=0.
- Requester changes d_addr 0x30→0x40 mid-ACCESS → ram_addr stays 0x30 until DONE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one basic_ram between the fetch and data ports.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles without ram_done.
module ram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_done
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  state_t state_reg;
  logic   last_grant_reg;
  logic   port_reg;
  logic   grant_d;
  logic   timeout;

  // Under contention the port that did not win last time gets the RAM.
  assign grant_d = (if_req && d_req) ? (last_grant_reg == PORT_IF) : d_req;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmr_reg;

  // A ram_done in the final cycle still counts as a normal completion.
  assign timeout = (tmr_reg == T_LAST) && !ram_done;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= PORT_D;
      port_reg       <= PORT_IF;
      ram_cs         <= 1'b0;
      ram_we         <= 1'b0;
      ram_oe         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      if_ack         <= 1'b0;
      d_ack          <= 1'b0;
      err            <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmr_reg        <= '0;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (if_req || d_req) begin
            port_reg       <= grant_d;
            last_grant_reg <= grant_d;
            ram_addr       <= grant_d ? d_addr : if_addr;
            ram_we         <= grant_d && d_we;
            ram_oe         <= !(grant_d && d_we);
            if (grant_d && d_we)
              ram_wdata <= d_wdata;
            ram_cs    <= 1'b1;
            state_reg <= ACCESS;
`ifdef MEM_TIMEOUT_EN
            tmr_reg   <= '0;
`endif
          end
        end
        ACCESS: begin
          if (ram_done || timeout) begin
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            err       <= timeout;
            state_reg <= DONE;
            if (port_reg == PORT_D)
              d_ack <= 1'b1;
            else
              if_ack <= 1'b1;
            // An aborted read returns zero rather than whatever is on the bus.
            if (!ram_we) begin
              if (port_reg == PORT_D)
                d_rdata <= ram_done ? ram_rdata : '0;
              else
                if_rdata <= ram_done ? ram_rdata : '0;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
`endif
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
